// File: rtl/snn_image_loader.sv
// snn_image_loader: unpacks a byte stream of binary pixels into the input-unit
// RAM, then runs one start/done handshake with the SNN core and holds the
// classified digit until the host acknowledges it.
module snn_image_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    output logic              ram_we,
    output logic              load_sel,
    output logic              snn_start,
    input  logic              snn_done,
    input  logic [3:0]        snn_digit,
    output logic [3:0]        result_digit,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_UNPACK,
        S_START,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        result_digit_q, result_digit_d;

    // State and datapath registers; reset abandons any partial image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LOAD;
            pix_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            result_digit_q <= '0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            result_digit_q <= result_digit_d;
        end
    end

    // Next-state logic and Moore-style outputs for the load/classify sequence.
    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        result_digit_d = result_digit_q;
        rx_ready       = 1'b0;
        load_sel       = 1'b0;
        ram_we         = 1'b0;
        ram_d          = 1'b0;
        snn_start      = 1'b0;
        result_valid   = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                rx_ready = 1'b1;
                load_sel = 1'b1;
                if (rx_valid) begin
                    shift_d   = rx_data;
                    bit_cnt_d = '0;
                    state_d   = S_UNPACK;
                end
            end
            S_UNPACK: begin
                load_sel  = 1'b1;
                ram_we    = 1'b1;
                ram_d     = shift_q[0];
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                // The counter returns to 0 after the last pixel instead of
                // stepping past the end, so ram_addr never leaves the image.
                if (pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d = '0;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (bit_cnt_q == 3'd7) begin
                    state_d = (pix_cnt_q == LAST_PIX) ? S_START : S_LOAD;
                end
            end
            S_START: begin
                snn_start = 1'b1;
                pix_cnt_d = '0;
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (snn_done) begin
                    result_digit_d = snn_digit;
                    state_d        = S_RESULT;
                end
            end
            S_RESULT: begin
                result_valid = 1'b1;
                if (result_ack) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign ram_addr     = pix_cnt_q;
    assign result_digit = result_digit_q;
    assign busy         = !((state_q == S_LOAD) && (pix_cnt_q == '0));

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader: full images, sparse pixel pattern,
// throttled byte stream, stray done pulses, result handshake, mid-image reset.
module tb_snn_image_loader;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_W     = 10;
    localparam int NBYTES     = NUM_PIXELS / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_we;
    logic              load_sel;
    logic              snn_start;
    logic              snn_done = 1'b0;
    logic [3:0]        snn_digit = '0;
    logic [3:0]        result_digit;
    logic              result_valid;
    logic              result_ack = 1'b0;
    logic              busy;

    snn_image_loader #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .load_sel(load_sel),
        .snn_start(snn_start), .snn_done(snn_done), .snn_digit(snn_digit),
        .result_digit(result_digit), .result_valid(result_valid),
        .result_ack(result_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    logic mon_clr = 1'b0;
    logic img [NUM_PIXELS];
    int   wr_cnt, exp_addr, order_err, rdy_err, start_cnt, start_cyc, rv_cnt, first_addr;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt = 0; exp_addr = 0; order_err = 0; rdy_err = 0;
            start_cnt = 0; start_cyc = -1; rv_cnt = 0; first_addr = -1;
            for (int i = 0; i < NUM_PIXELS; i++) img[i] = 1'b0;
        end else begin
            if (ram_we) begin
                if (first_addr < 0) first_addr = int'(ram_addr);
                if (int'(ram_addr) != exp_addr) order_err++;
                if (int'(ram_addr) < NUM_PIXELS) img[ram_addr] = ram_d;
                if (rx_ready) rdy_err++;
                exp_addr++;
                wr_cnt++;
            end
            if (snn_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (result_valid) rv_cnt++;
        end
    end

    logic [7:0] img_bytes [NBYTES];
    int acc_cyc;

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Feed n bytes from img_bytes; gap throttles rx_valid, inj drops stray
    // snn_done pulses in a LOAD cycle (27) and an UNPACK cycle (40).
    task automatic feed(input int n, input bit gap, input bit inj);
        int k = 0;
        int it = 0;
        bit acc;
        acc_cyc = -1;
        while (k < n && it < 5000) begin
            rx_valid  = gap ? (it % 3 != 2) : 1'b1;
            rx_data   = img_bytes[k];
            snn_done  = inj && (it == 27 || it == 40);
            snn_digit = 4'd3;
            acc = rx_valid && rx_ready;
            if (acc && k == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (acc) k++;
            it++;
        end
        rx_valid = 1'b0;
        snn_done = 1'b0;
        check("feed_bytes_accepted", k, n);
    endtask

    task automatic wait_start();
        int n = 0;
        while (start_cnt == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake(input int digit, input int delay, input int hold);
        int bad = 0;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        check("wait_load_sel", load_sel, 0);
        check("wait_rx_ready", rx_ready, 0);
        check("wait_busy", busy, 1);
        snn_done  = 1'b1;
        snn_digit = 4'(digit);
        @(posedge clk);
        #1 snn_done = 1'b0;
        snn_digit = 4'd0;
        check("result_valid_set", result_valid, 1);
        check("result_digit", result_digit, digit);
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!result_valid || result_digit != 4'(digit)) bad++;
        end
        check("result_held", bad, 0);
        result_ack = 1'b1;
        @(posedge clk);
        #1 result_ack = 1'b0;
        check("ack_result_valid", result_valid, 0);
        check("ack_rx_ready", rx_ready, 1);
        check("ack_busy", busy, 0);
        check("ack_digit_retained", result_digit, digit);
    endtask

    initial begin
        int ones;
        int pk;
        int mism;

        // Reset state while reset is held.
        #2;
        check("rst_rx_ready", rx_ready, 1);
        check("rst_load_sel", load_sel, 1);
        check("rst_ram_we", ram_we, 0);
        check("rst_snn_start", snn_start, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result_digit", result_digit, 0);
        check("rst_ram_addr", ram_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();

        // All-ones image, back-to-back bytes.
        for (int i = 0; i < NBYTES; i++) img_bytes[i] = 8'hFF;
        feed(NBYTES, 1'b0, 1'b0);
        wait_start();
        ones = 0;
        for (int i = 0; i < NUM_PIXELS; i++) ones += img[i];
        check("ff_writes", wr_cnt, NUM_PIXELS);
        check("ff_order", order_err, 0);
        check("ff_ones", ones, NUM_PIXELS);
        check("ff_start_cnt", start_cnt, 1);
        check("ff_start_latency", start_cyc - acc_cyc, 882);
        handshake(7, 200, 10);
        check("ff_single_start", start_cnt, 1);
        clear_mon();

        // 0xA5 then zeros, with stray done pulses during loading.
        img_bytes[0] = 8'hA5;
        for (int i = 1; i < NBYTES; i++) img_bytes[i] = 8'h00;
        feed(NBYTES, 1'b0, 1'b1);
        wait_start();
        pk = 0;
        for (int i = 0; i < 8; i++) pk |= int'(img[i]) << i;
        ones = 0;
        for (int i = 8; i < NUM_PIXELS; i++) ones += img[i];
        check("a5_first_byte", pk, 8'hA5);
        check("a5_rest_zero", ones, 0);
        check("a5_writes", wr_cnt, NUM_PIXELS);
        check("a5_order", order_err, 0);
        check("a5_stray_done_no_result", rv_cnt, 0);
        check("a5_stray_done_digit", result_digit, 7);
        check("a5_start_latency", start_cyc - acc_cyc, 882);
        handshake(5, 3, 0);
        clear_mon();

        // Varied bytes with rx_valid throttled.
        for (int i = 0; i < NBYTES; i++) img_bytes[i] = 8'((i * 29 + 3) & 8'hFF);
        feed(NBYTES, 1'b1, 1'b0);
        wait_start();
        mism = 0;
        for (int i = 0; i < NUM_PIXELS; i++)
            if (img[i] != img_bytes[i / 8][i % 8]) mism++;
        check("gap_contents", mism, 0);
        check("gap_writes", wr_cnt, NUM_PIXELS);
        check("gap_order", order_err, 0);
        check("gap_ready_in_unpack", rdy_err, 0);
        check("gap_start_cnt", start_cnt, 1);
        handshake(9, 5, 2);
        clear_mon();

        // Reset in the middle of byte 50's unpack.
        for (int i = 0; i < NBYTES; i++) img_bytes[i] = 8'hFF;
        feed(51, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_ram_we_before", ram_we, 1);
        rst = 1'b1;
        #1;
        check("mid_ram_we_after_rst", ram_we, 0);
        check("mid_busy_after_rst", busy, 0);
        check("mid_rx_ready_after_rst", rx_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        img_bytes[0] = 8'h01;
        feed(1, 1'b0, 1'b0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_first_addr", first_addr, 0);
        check("post_rst_writes", wr_cnt, 8);
        check("post_rst_order", order_err, 0);
        check("post_rst_pix0", img[0], 1);
        check("post_rst_no_start", start_cnt, 0);
        check("post_rst_busy_mid_image", busy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
